// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmit and receive sides.
//
// Contents:
//   uart_state_e       frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_NONE/EVEN/ODD  parity-mode codes carried in options[1:0]
//   OPT_*              bit positions inside the 8-bit options byte
//   BAUD_CNT_W         width of the per-bit clock counter
//   parity_enabled()   true when the mode code asks for a parity bit
//   parity_bit()       parity bit value for a data byte under a mode code
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Mode code 2'b11 is deliberately treated like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OPT_PAR_LSB   = 0;
  localparam int OPT_PAR_MSB   = 1;
  localparam int OPT_STOP2_BIT = 2;

  localparam int BAUD_CNT_W = 16;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Even parity makes the total count of ones even, so it is the plain XOR;
  // odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART.
//
// Ports:
//   clk_i       system clock (rising edge)
//   rst_ni      synchronous active-low reset
//   restart_i   restart the bit period from zero (asserted on byte acceptance)
//   bit_tick_o  high during the last clock of every bit period
//   pre_tick_o  high during the clock before bit_tick_o, so the user can
//               register an output that lines up with the final clock
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_tick_o,
  output logic pre_tick_o
);

  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_CNT_W-1:0] PRE_CNT  = BAUD_CNT_W'(CLKS_PER_BIT - 2);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;

  // Reload to zero at every bit boundary, so the count never drifts or wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = (cnt_q == LAST_CNT);
  assign pre_tick_o = (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8-bit UART transmitter with optional parity and 1/2 stop bits.
//
// Ports:
//   clk_clk        system clock (rising edge)
//   reset_reset_n  synchronous active-low reset
//   tx_data        byte to send, captured on acceptance
//   tx_valid       tx_data is offered
//   tx_ready       high only in IDLE; accept happens when valid and ready
//   tx_options     [1:0] parity mode, [2] two stop bits, [7:3] ignored
//   rs232_tx       registered serial line, idle high
//   tx_busy        high while a frame is on the line
//   tx_done        one-clock pulse during the last clock of the last stop bit
//
// Frame: start(0), 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// each bit CLKS_PER_BIT clocks long.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_options,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        par_en_q;
  logic        par_bit_q;
  logic        two_stop_q;
  logic        stop_cnt_q;
  logic        tx_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;

  logic accept;
  logic bit_tick;
  logic pre_tick;
  logic last_stop;
  logic unused_opts;

  assign accept      = tx_valid && ready_q;
  assign last_stop   = !two_stop_q || stop_cnt_q;
  assign unused_opts = ^tx_options[7:3];

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .restart_i  (accept),
    .bit_tick_o (bit_tick),
    .pre_tick_o (pre_tick)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (accept) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            shift_q    <= tx_data;
            par_en_q   <= parity_enabled(tx_options[OPT_PAR_MSB:OPT_PAR_LSB]);
            par_bit_q  <= parity_bit(tx_data, tx_options[OPT_PAR_MSB:OPT_PAR_LSB]);
            two_stop_q <= tx_options[OPT_STOP2_BIT];
          end else begin
            ready_q <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= '0;
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == 3'd7) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= STOP;
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            state_q    <= STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end

        STOP: begin
          // Registered one clock early so the pulse occupies the final clock
          // of the stop bit, and tx_ready follows on the clock after.
          if (last_stop && pre_tick) begin
            done_q <= 1'b1;
          end
          if (bit_tick) begin
            if (last_stop) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign rs232_tx = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with CLKS_PER_BIT = 4.
// Every clock of each frame is compared against a hand-written bit sequence
// (listed first-bit-first, most significant position = start bit).
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk_clk       = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [7:0] tx_data       = 8'h00;
  logic       tx_valid      = 1'b0;
  logic [7:0] tx_options    = 8'h00;
  logic       tx_ready;
  logic       rs232_tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_options    (tx_options),
    .rs232_tx      (rs232_tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a byte, then check every clock of the frame plus the idle clock
  // after it. exp_bits[nbits-1] is the start bit.
  task automatic send_frame(input string name, input logic [7:0] data,
                            input logic [7:0] opts, input logic [11:0] exp_bits,
                            input int nbits, input bit hold,
                            input int mid_cycle, input logic [7:0] mid_data,
                            output int waited);
    int len;
    len        = nbits * CPB;
    tx_data    = data;
    tx_options = opts;
    tx_valid   = 1'b1;
    waited     = 0;
    while (!tx_ready && waited < 100) begin
      @(negedge clk_clk);
      waited++;
    end
    chk({name, " ready_before_accept"}, 32'(tx_ready), 32'd1);
    @(posedge clk_clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk_clk);
      chk($sformatf("%s line c%0d", name, c), 32'(rs232_tx), 32'(exp_bits[nbits - 1 - (c - 1) / CPB]));
      chk($sformatf("%s done c%0d", name, c), 32'(tx_done), 32'(c == len));
      chk($sformatf("%s busy c%0d", name, c), 32'(tx_busy), 32'd1);
      chk($sformatf("%s ready c%0d", name, c), 32'(tx_ready), 32'd0);
      if (c == mid_cycle) tx_data = mid_data;
    end
    @(negedge clk_clk);
    chk({name, " idle line"},  32'(rs232_tx), 32'd1);
    chk({name, " idle ready"}, 32'(tx_ready), 32'd1);
    chk({name, " idle busy"},  32'(tx_busy),  32'd0);
    chk({name, " idle done"},  32'(tx_done),  32'd0);
    $display("frame %s data=0x%02h opts=0x%02h clocks=%0d", name, data, opts, len);
  endtask

  initial begin
    int  w;
    bit  saw_done;

    // Reset state
    repeat (3) @(negedge clk_clk);
    chk("reset line",  32'(rs232_tx), 32'd1);
    chk("reset ready", 32'(tx_ready), 32'd0);
    chk("reset busy",  32'(tx_busy),  32'd0);
    chk("reset done",  32'(tx_done),  32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("ready after release", 32'(tx_ready), 32'd1);

    // Test 1: 0x55 even parity -> 0 10101010 0 1
    send_frame("t1", 8'h55, 8'h01, 12'b0_1010_1010_0_1, 11, 1'b0, 0, 8'h00, w);
    // Test 2: 0xA3 odd parity -> 0 11000101 1 1
    send_frame("t2", 8'hA3, 8'h02, 12'b0_1100_0101_1_1, 11, 1'b0, 0, 8'h00, w);
    // Test 3: 0xFF no parity, two stop bits -> 0 11111111 1 1
    send_frame("t3", 8'hFF, 8'h04, 12'b0_1111_1111_1_1, 11, 1'b0, 0, 8'h00, w);
    // Test 4: back-to-back with tx_valid held high
    send_frame("t4a", 8'h01, 8'h00, 12'b0_1000_0000_1, 10, 1'b1, 0, 8'h00, w);
    send_frame("t4b", 8'h80, 8'h00, 12'b0_0000_0001_1, 10, 1'b0, 0, 8'h00, w);
    chk("t4 idle gap waits", 32'(w), 32'd0);
    // Test 5: tx_data altered mid-frame; line still carries 0x3C
    send_frame("t5", 8'h3C, 8'h00, 12'b0_0011_1100_1, 10, 1'b0, 10, 8'h00, w);

    // Test 6: reset in the middle of the data bits of 0x0F
    tx_data    = 8'h0F;
    tx_options = 8'h00;
    tx_valid   = 1'b1;
    @(posedge clk_clk);
    #1;
    tx_valid = 1'b0;
    repeat (22) @(negedge clk_clk);
    chk("t6 data bit4 line", 32'(rs232_tx), 32'd0);
    chk("t6 busy before reset", 32'(tx_busy), 32'd1);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk("t6 line after reset",  32'(rs232_tx), 32'd1);
    chk("t6 ready in reset",    32'(tx_ready), 32'd0);
    chk("t6 busy in reset",     32'(tx_busy),  32'd0);
    chk("t6 done in reset",     32'(tx_done),  32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("t6 ready after release", 32'(tx_ready), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done) saw_done = 1'b1;
      @(negedge clk_clk);
    end
    chk("t6 no tx_done after abort", 32'(saw_done), 32'd0);
    chk("t6 line idle after abort",  32'(rs232_tx), 32'd1);
    $display("frame t6 data=0x0f aborted by reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
